// File: rtl/sprite_draw_engine_if.sv
// Command and shared-memory port bundle for sprite_draw_engine.
// master = cpu/memory side, slave = the draw engine.
interface sprite_draw_engine_if;
    logic        start;
    logic [11:0] sprite_addr;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [3:0]  rows;
    logic        busy;
    logic        done;
    logic        collision;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic        mem_read_ack;
    logic [7:0]  mem_read_byte;
    logic        mem_write;
    logic [11:0] mem_write_idx;
    logic [7:0]  mem_write_byte;

    modport master (
        output start, sprite_addr, vx, vy, rows, mem_read_ack, mem_read_byte,
        input  busy, done, collision, mem_read, mem_read_idx,
               mem_write, mem_write_idx, mem_write_byte
    );

    modport slave (
        input  start, sprite_addr, vx, vy, rows, mem_read_ack, mem_read_byte,
        output busy, done, collision, mem_read, mem_read_idx,
               mem_write, mem_write_idx, mem_write_byte
    );
endinterface

// File: rtl/sprite_draw_engine.sv
// CHIP-8 DRW engine: XORs sprite rows into the 64x32 framebuffer at 0x100 over the shared byte port.
// Optional macro DRAW_CLIP_EN: drop pixels past the right/bottom edge instead of wrapping.
module sprite_draw_engine (
    input  logic                clk,
    input  logic                reset,
    sprite_draw_engine_if.slave bus
);
    localparam logic [11:0] FB_BASE = 12'h100;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_SPR, S_LOAD_L, S_STORE_L, S_LOAD_R, S_STORE_R, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [11:0] r_base;
    logic [2:0]  r_col, r_shift;
    logic [4:0]  r_row;
    logic [3:0]  r_count, r_i;
    logic [7:0]  r_spr, r_fb;
    logic        r_coll;

    logic        w_accept, w_coll_set, w_row_adv, w_last, w_clip_y, w_clip_r;
    logic [4:0]  w_r;
    logic [2:0]  w_col_r;
    logic [11:0] w_addr_l, w_addr_r;
    logic [7:0]  w_part_l, w_part_r;
    logic        w_mem_read, w_mem_write, w_done;
    logic [11:0] w_read_idx, w_write_idx;
    logic [7:0]  w_write_byte;
    logic        w_unused_bits;

    assign w_accept      = (r_state == S_IDLE) && bus.start;
    assign w_r           = r_row + {1'b0, r_i};
    assign w_col_r       = r_col + 3'd1;
    assign w_addr_l      = FB_BASE + {4'd0, w_r, r_col};
    assign w_addr_r      = FB_BASE + {4'd0, w_r, w_col_r};
    assign w_part_l      = r_spr >> r_shift;
    // Right-hand part is only used with shift != 0, so (0 - shift) mod 8 equals 8 - shift.
    assign w_part_r      = r_spr << (3'd0 - r_shift);
    assign w_unused_bits = ^{bus.vx[7:6], bus.vy[7:5]};

`ifdef DRAW_CLIP_EN
    // Once a row falls below the screen every later row does too, so finish immediately.
    assign w_clip_y = ({1'b0, r_row} + {2'b0, r_i} + 6'd1) >= 6'd32;
    assign w_clip_r = (r_col == 3'd7);
`else
    assign w_clip_y = 1'b0;
    assign w_clip_r = 1'b0;
`endif

    assign w_last = (({1'b0, r_i} + 5'd1) == {1'b0, r_count}) || w_clip_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_coll  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_coll <= 1'b0;
            else if (w_coll_set)
                r_coll <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_base  <= bus.sprite_addr;
            r_col   <= bus.vx[5:3];
            r_shift <= bus.vx[2:0];
            r_row   <= bus.vy[4:0];
            r_count <= bus.rows;
            r_i     <= 4'd0;
        end else if (w_row_adv) begin
            r_i <= r_i + 4'd1;
        end
        if (r_state == S_LOAD_SPR && bus.mem_read_ack)
            r_spr <= bus.mem_read_byte;
        if ((r_state == S_LOAD_L || r_state == S_LOAD_R) && bus.mem_read_ack)
            r_fb <= bus.mem_read_byte;
    end

    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_read_idx   = 12'd0;
        w_mem_write  = 1'b0;
        w_write_idx  = 12'd0;
        w_write_byte = 8'd0;
        w_coll_set   = 1'b0;
        w_row_adv    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = (bus.rows == 4'd0) ? S_DONE : S_LOAD_SPR;
            end
            S_LOAD_SPR: begin
                w_mem_read = !bus.mem_read_ack;
                w_read_idx = r_base + {8'd0, r_i};
                if (bus.mem_read_ack)
                    w_next = S_LOAD_L;
            end
            S_LOAD_L: begin
                w_mem_read = !bus.mem_read_ack;
                w_read_idx = w_addr_l;
                if (bus.mem_read_ack)
                    w_next = S_STORE_L;
            end
            S_STORE_L: begin
                w_mem_write  = 1'b1;
                w_write_idx  = w_addr_l;
                w_write_byte = r_fb ^ w_part_l;
                w_coll_set   = |(r_fb & w_part_l);
                if (r_shift != 3'd0 && !w_clip_r) begin
                    w_next = S_LOAD_R;
                end else begin
                    w_row_adv = 1'b1;
                    w_next    = w_last ? S_DONE : S_LOAD_SPR;
                end
            end
            S_LOAD_R: begin
                w_mem_read = !bus.mem_read_ack;
                w_read_idx = w_addr_r;
                if (bus.mem_read_ack)
                    w_next = S_STORE_R;
            end
            S_STORE_R: begin
                w_mem_write  = 1'b1;
                w_write_idx  = w_addr_r;
                w_write_byte = r_fb ^ w_part_r;
                w_coll_set   = |(r_fb & w_part_r);
                w_row_adv    = 1'b1;
                w_next       = w_last ? S_DONE : S_LOAD_SPR;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = w_done;
    assign bus.collision      = r_coll;
    assign bus.mem_read       = w_mem_read;
    assign bus.mem_read_idx   = w_read_idx;
    assign bus.mem_write      = w_mem_write;
    assign bus.mem_write_idx  = w_write_idx;
    assign bus.mem_write_byte = w_write_byte;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboard bench for sprite_draw_engine: directed draws with hand-computed framebuffer results.
// Expectations for the wrap test follow DRAW_CLIP_EN when that macro is defined.
module tb_sprite_draw_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_draw_engine_if bus();
    sprite_draw_engine dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic             coll;
        int               busy;
        int               n;
        logic [3:0][11:0] a;
        logic [7:0][7:0]  d;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [7:0] mem [0:4095];
    logic       tb_wr, tb_clr, fin;
    logic [11:0] tb_wa;
    logic [7:0]  tb_wd;
    int         checks = 0;
    int         errors = 0;
    int         bcnt = 0;
    logic       last_coll = 1'b0;

    // Byte memory with one-cycle read acknowledge; bench preload and fb clear share the same port process.
    always @(posedge clk) begin
        bus.mem_read_ack <= 1'b0;
        if (bus.mem_read) begin
            bus.mem_read_ack  <= 1'b1;
            bus.mem_read_byte <= mem[bus.mem_read_idx];
        end
        if (tb_clr)
            for (int k = 256; k < 512; k++) mem[k] <= 8'h00;
        if (bus.mem_write) mem[bus.mem_write_idx] <= bus.mem_write_byte;
        if (tb_wr) mem[tb_wa] <= tb_wd;
    end

    function automatic exp_t mk(input logic c, input int b, input int n,
                                input logic [11:0] a0, input logic [7:0] d0,
                                input logic [11:0] a1, input logic [7:0] d1,
                                input logic [11:0] a2, input logic [7:0] d2,
                                input logic [11:0] a3, input logic [7:0] d3);
        exp_t x;
        x.coll = c; x.busy = b; x.n = n;
        x.a = '0; x.d = '0;
        x.a[0] = a0; x.d[0] = d0; x.a[1] = a1; x.d[1] = d1;
        x.a[2] = a2; x.d[2] = d2; x.a[3] = a3; x.d[3] = d3;
        return x;
    endfunction

    // Monitor: sole owner of the check/error counters.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (bus.busy || bus.done || bus.collision || bus.mem_read || bus.mem_write ||
                bus.mem_read_idx != 12'd0 || bus.mem_write_idx != 12'd0 || bus.mem_write_byte != 8'd0) begin
                errors++;
                $display("FAIL reset_outputs: busy=%b done=%b coll=%b rd=%b wr=%b ridx=%h widx=%h wbyte=%h, required all zero",
                         bus.busy, bus.done, bus.collision, bus.mem_read, bus.mem_write,
                         bus.mem_read_idx, bus.mem_write_idx, bus.mem_write_byte);
            end
            bcnt = 0;
            last_coll = 1'b0;
        end else begin
            checks++;
            if (bus.mem_read && bus.mem_write) begin
                errors++;
                $display("FAIL rw_exclusive: mem_read=1 mem_write=1, required at most one high");
            end
            if (bus.busy) bcnt++;
            else begin
                checks++;
                if (bus.collision !== last_coll) begin
                    errors++;
                    $display("FAIL collision_hold: got %b, required %b", bus.collision, last_coll);
                end
            end
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done=1, required no pending draw");
                end else begin
                    e = sbq.pop_front();
                    checks++;
                    if (bus.collision !== e.coll) begin
                        errors++;
                        $display("FAIL collision: got %b, required %b", bus.collision, e.coll);
                    end
                    checks++;
                    if (bcnt != e.busy) begin
                        errors++;
                        $display("FAIL busy_cycles: got %0d, required %0d", bcnt, e.busy);
                    end
                    for (int k = 0; k < e.n; k++) begin
                        checks++;
                        if (mem[e.a[k]] !== e.d[k]) begin
                            errors++;
                            $display("FAIL fb_byte[%h]: got %h, required %h", e.a[k], mem[e.a[k]], e.d[k]);
                        end
                    end
                    last_coll = e.coll;
                end
                bcnt = 0;
            end
            if (fin) begin
                checks++;
                if (sbq.size() != 0) begin
                    errors++;
                    $display("FAIL pending_draws: got %0d outstanding, required 0", sbq.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic clear_fb();
        @(negedge clk);
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
    endtask

    task automatic issue(input logic [11:0] sa, input logic [7:0] x, input logic [7:0] y, input logic [3:0] n);
        @(negedge clk);
        bus.sprite_addr = sa; bus.vx = x; bus.vy = y; bus.rows = n; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic draw(input logic [11:0] sa, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input exp_t ex);
        sbq.push_back(ex);
        issue(sa, x, y, n);
        for (int t = 0; t < 200 && sbq.size() != 0; t++) @(negedge clk);
        if (sbq.size() != 0) begin
            $display("FAIL draw_timeout: done not seen within 200 cycles, required completion");
            $fatal(1, "draw timeout");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.sprite_addr = 12'd0; bus.vx = 8'd0; bus.vy = 8'd0; bus.rows = 4'd0;
        tb_wr = 1'b0; tb_clr = 1'b0; tb_wa = 12'd0; tb_wd = 8'd0; fin = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        clear_fb();
        poke(12'h300, 8'hF0);
        draw(12'h300, 8'd0, 8'd0, 4'd1, mk(1'b0, 6, 1, 12'h100, 8'hF0, 0, 0, 0, 0, 0, 0));
        draw(12'h300, 8'd0, 8'd0, 4'd1, mk(1'b1, 6, 1, 12'h100, 8'h00, 0, 0, 0, 0, 0, 0));
        draw(12'h300, 8'd0, 8'd0, 4'd0, mk(1'b0, 1, 1, 12'h100, 8'h00, 0, 0, 0, 0, 0, 0));

        clear_fb();
        poke(12'h300, 8'hFF);
        draw(12'h300, 8'd3, 8'd1, 4'd1, mk(1'b0, 9, 2, 12'h108, 8'h1F, 12'h109, 8'hE0, 0, 0, 0, 0));
        draw(12'h300, 8'd3, 8'd1, 4'd1, mk(1'b1, 9, 2, 12'h108, 8'h00, 12'h109, 8'h00, 0, 0, 0, 0));

        clear_fb();
        poke(12'h301, 8'hFF);
`ifdef DRAW_CLIP_EN
        draw(12'h300, 8'd60, 8'd31, 4'd2,
             mk(1'b0, 6, 4, 12'h1FF, 8'h0F, 12'h1F8, 8'h00, 12'h107, 8'h00, 12'h100, 8'h00));
`else
        draw(12'h300, 8'd60, 8'd31, 4'd2,
             mk(1'b0, 17, 4, 12'h1FF, 8'h0F, 12'h1F8, 8'hF0, 12'h107, 8'h0F, 12'h100, 8'hF0));
`endif

        // Reset in the third busy cycle of a 4-row draw; no done may follow.
        clear_fb();
        @(negedge clk);
        bus.sprite_addr = 12'h300; bus.vx = 8'd0; bus.vy = 8'd0; bus.rows = 4'd4; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);

        poke(12'h300, 8'hF0);
        draw(12'h300, 8'd0, 8'd0, 4'd1, mk(1'b0, 6, 1, 12'h100, 8'hF0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        fin = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end
endmodule
